// File: rtl/priority_encoder_core.sv
// Combinational MSB-first priority encode of a request vector, gated by enable.
// Scales with WIDTH: a loop walks upward, so the highest set bit is the last
// assignment and wins.
module priority_encoder_core #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] I,
  input  logic             en,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  // Highest-index active request; idx stays 0 and any stays low when disabled or idle
  always_comb begin
    idx = '0;
    any = 1'b0;
    if (en) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (I[k]) begin
          idx = OUT_W'(k);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Registered WIDTH-to-log2(WIDTH) priority encoder. The highest-numbered
// asserted request wins. Outputs update one clock after en/I are sampled.
module priority_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         I,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] F,
  output logic                     valid
);

  localparam int OUT_W = $clog2(WIDTH);

  logic [OUT_W-1:0] idx_p0;
  logic             vld_p0;
  logic [OUT_W-1:0] f_p1;
  logic             vld_p1;

  priority_encoder_core #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_core (
    .I   (I),
    .en  (en),
    .idx (idx_p0),
    .any (vld_p0)
  );

  // Stage p0 -> p1: output register; reset clears both index and valid so idle reads F=0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      f_p1   <= idx_p0;
      vld_p1 <= vld_p0;
    end
  end

  assign F     = f_p1;
  assign valid = vld_p1;

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: directed vectors push expected
// results into a queue; a monitor pops one entry per clock edge and checks it.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] I;
  logic       en;
  logic [2:0] F;
  logic       valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] f;
    logic       v;
    logic [7:0] i;
  } exp_t;

  exp_t exp_q[$];

  priority_encoder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (I),
    .en    (en),
    .F     (F),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge; its result is expected after the next rising edge
  task automatic apply(input logic r, input logic e, input logic [7:0] iv,
                       input logic [2:0] ef, input logic ev);
    exp_t x;
    @(negedge clk);
    rst_n = r;
    en    = e;
    I     = iv;
    x.f = ef;
    x.v = ev;
    x.i = iv;
    exp_q.push_back(x);
  endtask

  // Monitor: check right after each rising edge, then again just before the next one
  initial begin
    exp_t x;
    logic [2:0] sf;
    logic       sv;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        sf = F;
        sv = valid;
        total++;
        if (sf !== x.f || sv !== x.v) begin
          bad++;
          $display("FAIL encode I=%02h: got F=%0d valid=%0b, want F=%0d valid=%0b",
                   x.i, sf, sv, x.f, x.v);
        end
        #7;
        total++;
        if (F !== sf || valid !== sv) begin
          bad++;
          $display("FAIL stable I=%02h: F=%0d valid=%0b changed mid-cycle from F=%0d valid=%0b",
                   x.i, F, valid, sf, sv);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    I     = 8'h00;

    // Reset held two edges with active requests
    apply(1'b0, 1'b1, 8'hFF, 3'd0, 1'b0);
    apply(1'b0, 1'b1, 8'hFF, 3'd0, 1'b0);
    apply(1'b1, 1'b1, 8'hFF, 3'd7, 1'b1);

    // Disabled
    apply(1'b1, 1'b0, 8'h01, 3'd0, 1'b0);
    apply(1'b1, 1'b0, 8'hFF, 3'd0, 1'b0);

    // One-hot sweep
    for (int k = 0; k < 8; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << k;
      apply(1'b1, 1'b1, oh, 3'(k), 1'b1);
    end

    // Multi-bit priority
    apply(1'b1, 1'b1, 8'h2E, 3'd5, 1'b1);
    apply(1'b1, 1'b1, 8'h6E, 3'd6, 1'b1);
    apply(1'b1, 1'b1, 8'hAE, 3'd7, 1'b1);
    apply(1'b1, 1'b1, 8'hAF, 3'd7, 1'b1);
    apply(1'b1, 1'b1, 8'h6F, 3'd6, 1'b1);
    apply(1'b1, 1'b1, 8'h3E, 3'd5, 1'b1);

    // Empty then a request
    apply(1'b1, 1'b1, 8'h00, 3'd0, 1'b0);
    apply(1'b1, 1'b1, 8'h10, 3'd4, 1'b1);

    // Mid-stream reset, then recovery one edge later
    apply(1'b1, 1'b1, 8'h03, 3'd1, 1'b1);
    apply(1'b0, 1'b1, 8'h80, 3'd0, 1'b0);
    apply(1'b1, 1'b1, 8'h80, 3'd7, 1'b1);
    apply(1'b1, 1'b1, 8'h01, 3'd0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      repeat (2) @(posedge clk);
      if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
